// File: rtl/shift_req_pipe.sv
// rtl/shift_req_pipe.sv - FIFO-buffered, registered, back-pressurable front end for barrelshifter32

module barrelshifter32 (
    input  logic [31:0] a,
    input  logic [5:0]  b,
    input  logic [2:0]  aluc,
    output logic [31:0] c
);
    logic        w_fill;
    logic [63:0] w_ext;
    logic [63:0] w_right;

    // Right shifts run on a 64-bit sign/zero-extended copy, so amounts of 32..63 fill completely.
    always_comb begin
        w_fill  = 1'b0;
        c       = 32'd0;
        casez (aluc)
            3'b?00:  w_fill = a[31];
            default: w_fill = 1'b0;
        endcase
        w_ext   = {{32{w_fill}}, a};
        w_right = w_ext >> b;
        casez (aluc)
            3'b?1?:  c = a << b;
            default: c = w_right[31:0];
        endcase
    end
endmodule

module shift_req_pipe #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_a,
    input  logic [5:0]               in_b,
    input  logic [2:0]               in_aluc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_c,
    output logic                     out_zero,
    output logic                     out_neg,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]         op_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]      r_mem_a    [DEPTH];
    logic [5:0]       r_mem_b    [DEPTH];
    logic [2:0]       r_mem_aluc [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_out_valid;
    logic [31:0]      r_out_c;
    logic             r_out_zero;
    logic             r_out_neg;
    logic [CNT_W-1:0] r_op_count;

    logic             w_pop;
    logic             w_push;
    logic [31:0]      w_c;

    // A full FIFO still accepts when its head leaves in the same cycle.
    assign w_pop    = (!r_out_valid || out_ready) && (r_count != '0);
    assign in_ready = (r_count < FULL) || w_pop;
    assign w_push   = in_valid && in_ready;

    barrelshifter32 u_shifter (
        .a    (r_mem_a[r_rd_ptr]),
        .b    (r_mem_b[r_rd_ptr]),
        .aluc (r_mem_aluc[r_rd_ptr]),
        .c    (w_c)
    );

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr]    <= in_a;
            r_mem_b[r_wr_ptr]    <= in_b;
            r_mem_aluc[r_wr_ptr] <= in_aluc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_c     <= 32'd0;
            r_out_zero  <= 1'b1;
            r_out_neg   <= 1'b0;
            r_op_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);

            if (r_out_valid && out_ready) begin
                r_op_count <= r_op_count + CNT_W'(1);
            end

            if (w_pop) begin
                r_out_valid <= 1'b1;
                r_out_c     <= w_c;
                r_out_zero  <= (w_c == 32'd0);
                r_out_neg   <= w_c[31];
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_c      = r_out_c;
    assign out_zero   = r_out_zero;
    assign out_neg    = r_out_neg;
    assign fifo_count = r_count;
    assign op_count   = r_op_count;
endmodule

// File: tb/tb_shift_req_pipe.sv
// tb/tb_shift_req_pipe.sv - directed self-checking bench for shift_req_pipe

module tb_shift_req_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [5:0]  in_b;
    logic [2:0]  in_aluc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_c;
    logic        out_zero;
    logic        out_neg;
    logic [2:0]  fifo_count;
    logic [3:0]  op_count;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [3:0]  exp_ops = 4'd0;
    logic [31:0] exp_q [5];

    always #5 clk = ~clk;

    shift_req_pipe #(.DEPTH(4), .CNT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_aluc    (in_aluc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_c      (out_c),
        .out_zero   (out_zero),
        .out_neg    (out_neg),
        .fifo_count (fifo_count),
        .op_count   (op_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [5:0] b, input logic [2:0] op);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_aluc  = op;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'd0, 6'd0, 3'd0);
        tick();
        tick();
        rst_n = 1'b1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        n_tests++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
        n_tests++; if (out_c !== 32'd0) begin n_fail++; $display("FAIL reset_c got %h exp 0", out_c); end
        n_tests++; if (out_zero !== 1'b1) begin n_fail++; $display("FAIL reset_zero got %b exp 1", out_zero); end
        n_tests++; if (out_neg !== 1'b0) begin n_fail++; $display("FAIL reset_neg got %b exp 0", out_neg); end
        n_tests++; if (op_count !== 4'd0) begin n_fail++; $display("FAIL reset_ops got %0d exp 0", op_count); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        drive(1'b1, 32'hF0C3961E, 6'd4, 3'b010);
        tick();
        drive(1'b0, 32'd0, 6'd0, 3'd0);
        n_tests++; if (out_valid !== 1'b0 || fifo_count !== 3'd1) begin n_fail++; $display("FAIL basic_queued got v=%b cnt=%0d exp v=0 cnt=1", out_valid, fifo_count); end
        tick();
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b exp 1", out_valid); end
        n_tests++; if (out_c !== 32'h0C3961E0) begin n_fail++; $display("FAIL basic_c got %h exp 0c3961e0", out_c); end
        n_tests++; if (out_zero !== 1'b0 || out_neg !== 1'b0) begin n_fail++; $display("FAIL basic_flags got z=%b n=%b exp z=0 n=0", out_zero, out_neg); end
        tick();
        exp_ops = exp_ops + 4'd1;
        n_tests++; if (op_count !== exp_ops) begin n_fail++; $display("FAIL basic_ops got %0d exp %0d", op_count, exp_ops); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_ops();
        out_ready = 1'b1;
        drive(1'b1, 32'hF0C3961E, 6'd4, 3'b000);
        tick();
        drive(1'b1, 32'hF0C3961E, 6'd4, 3'b001);
        tick();
        n_tests++; if (out_valid !== 1'b1 || out_c !== 32'hFF0C3961 || out_neg !== 1'b1) begin n_fail++; $display("FAIL ops_sra got v=%b c=%h n=%b exp v=1 c=ff0c3961 n=1", out_valid, out_c, out_neg); end
        drive(1'b1, 32'hF0C3961E, 6'd4, 3'b011);
        tick();
        n_tests++; if (out_valid !== 1'b1 || out_c !== 32'h0F0C3961 || out_neg !== 1'b0) begin n_fail++; $display("FAIL ops_srl got v=%b c=%h n=%b exp v=1 c=0f0c3961 n=0", out_valid, out_c, out_neg); end
        drive(1'b0, 32'd0, 6'd0, 3'd0);
        tick();
        n_tests++; if (out_valid !== 1'b1 || out_c !== 32'h0C3961E0 || out_neg !== 1'b0) begin n_fail++; $display("FAIL ops_sll got v=%b c=%h n=%b exp v=1 c=0c3961e0 n=0", out_valid, out_c, out_neg); end
        tick();
        exp_ops = exp_ops + 4'd3;
        n_tests++; if (out_valid !== 1'b0 || op_count !== exp_ops) begin n_fail++; $display("FAIL ops_end got v=%b ops=%0d exp v=0 ops=%0d", out_valid, op_count, exp_ops); end
    endtask

    task automatic test_backpressure();
        exp_q[0] = 32'h11111111;
        exp_q[1] = 32'h44444444;
        exp_q[2] = 32'hCCCCCCCC;
        exp_q[3] = 32'h22222220;
        exp_q[4] = 32'h55555550;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h11111111 * (i + 1), 6'(i), 3'b010);
            tick();
        end
        drive(1'b0, 32'd0, 6'd0, 3'd0);
        #1;
        n_tests++; if (fifo_count !== 3'd4 || in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full got cnt=%0d rdy=%b exp cnt=4 rdy=0", fifo_count, in_ready); end
        n_tests++; if (out_valid !== 1'b1 || out_c !== exp_q[0]) begin n_fail++; $display("FAIL bp_head got v=%b c=%h exp v=1 c=%h", out_valid, out_c, exp_q[0]); end
        tick();
        n_tests++; if (out_c !== exp_q[0] || fifo_count !== 3'd4) begin n_fail++; $display("FAIL bp_hold got c=%h cnt=%0d exp c=%h cnt=4", out_c, fifo_count, exp_q[0]); end
        out_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            tick();
            n_tests++; if (out_valid !== 1'b1 || out_c !== exp_q[k]) begin n_fail++; $display("FAIL bp_drain%0d got v=%b c=%h exp v=1 c=%h", k, out_valid, out_c, exp_q[k]); end
        end
        tick();
        exp_ops = exp_ops + 4'd5;
        n_tests++; if (out_valid !== 1'b0 || op_count !== exp_ops) begin n_fail++; $display("FAIL bp_end got v=%b ops=%0d exp v=0 ops=%0d", out_valid, op_count, exp_ops); end
    endtask

    task automatic test_full_push_pop();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'hA0 + i, 6'd0, 3'b010);
            tick();
        end
        drive(1'b1, 32'hA5, 6'd0, 3'b010);
        out_ready = 1'b1;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_in_ready got %b exp 1", in_ready); end
        tick();
        drive(1'b0, 32'd0, 6'd0, 3'd0);
        n_tests++; if (fifo_count !== 3'd4 || out_c !== 32'hA1) begin n_fail++; $display("FAIL full_swap got cnt=%0d c=%h exp cnt=4 c=a1", fifo_count, out_c); end
        for (int k = 2; k < 6; k++) begin
            tick();
            n_tests++; if (out_valid !== 1'b1 || out_c !== 32'hA0 + k) begin n_fail++; $display("FAIL full_drain%0d got v=%b c=%h exp v=1 c=%h", k, out_valid, out_c, 32'hA0 + k); end
        end
        tick();
        exp_ops = exp_ops + 4'd6;
        n_tests++; if (out_valid !== 1'b0 || op_count !== exp_ops) begin n_fail++; $display("FAIL full_end got v=%b ops=%0d exp v=0 ops=%0d", out_valid, op_count, exp_ops); end
    endtask

    task automatic test_zero_wrap();
        out_ready = 1'b1;
        drive(1'b1, 32'h80000000, 6'd1, 3'b010);
        tick();
        drive(1'b1, 32'h80000000, 6'd31, 3'b100);
        tick();
        n_tests++; if (out_c !== 32'd0 || out_zero !== 1'b1 || out_neg !== 1'b0) begin n_fail++; $display("FAIL zero_flag got c=%h z=%b n=%b exp c=0 z=1 n=0", out_c, out_zero, out_neg); end
        drive(1'b0, 32'd0, 6'd0, 3'd0);
        tick();
        n_tests++; if (op_count !== 4'd0) begin n_fail++; $display("FAIL wrap_16 got %0d exp 0", op_count); end
        n_tests++; if (out_c !== 32'hFFFFFFFF || out_neg !== 1'b1 || out_zero !== 1'b0) begin n_fail++; $display("FAIL sra_alias got c=%h n=%b z=%b exp c=ffffffff n=1 z=0", out_c, out_neg, out_zero); end
        tick();
        n_tests++; if (op_count !== 4'd1) begin n_fail++; $display("FAIL wrap_17 got %0d exp 1", op_count); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h1234 + i, 6'd0, 3'b010);
            tick();
        end
        drive(1'b0, 32'd0, 6'd0, 3'd0);
        n_tests++; if (out_valid !== 1'b1 || fifo_count !== 3'd3) begin n_fail++; $display("FAIL mid_setup got v=%b cnt=%0d exp v=1 cnt=3", out_valid, fifo_count); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_tests++; if (out_valid !== 1'b0 || fifo_count !== 3'd0 || op_count !== 4'd0) begin n_fail++; $display("FAIL mid_reset got v=%b cnt=%0d ops=%0d exp 0 0 0", out_valid, fifo_count, op_count); end
        n_tests++; if (out_c !== 32'd0 || out_zero !== 1'b1) begin n_fail++; $display("FAIL mid_reset_c got c=%h z=%b exp c=0 z=1", out_c, out_zero); end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_tests++; if (out_valid !== 1'b0 || op_count !== 4'd0) begin n_fail++; $display("FAIL mid_stale%0d got v=%b ops=%0d exp v=0 ops=0", k, out_valid, op_count); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ops();
        test_backpressure();
        test_full_push_pop();
        test_zero_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
